// File: rtl/flex_down_timer.sv
// rtl/flex_down_timer.sv - loadable down-counting timer with one-shot and auto-reload modes
module flex_down_timer #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    periodic,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire_flag,
    output logic                    busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [NUM_CNT_BITS-1:0] reload_val;
    logic                    periodic_mode;

    // Timer state machine; the if/else chain encodes rst > clear > load > tick priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count_out     <= CNT_ZERO;
            reload_val    <= CNT_ZERO;
            periodic_mode <= 1'b0;
            expire_flag   <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            count_out   <= CNT_ZERO;
            expire_flag <= 1'b0;
        end else if (load) begin
            // A zero load value would arm a timer that can never expire, so it is dropped
            // along with any tick arriving in the same cycle.
            if (load_val != CNT_ZERO) begin
                state         <= RUN;
                count_out     <= load_val;
                reload_val    <= load_val;
                periodic_mode <= periodic;
            end
            expire_flag <= 1'b0;
        end else if (state == RUN && count_enable) begin
            if (count_out > CNT_ONE) begin
                count_out   <= count_out - CNT_ONE;
                expire_flag <= 1'b0;
            end else if (count_out == CNT_ONE) begin
                expire_flag <= 1'b1;
                if (periodic_mode) begin
                    count_out <= reload_val;
                end else begin
                    count_out <= CNT_ZERO;
                    state     <= IDLE;
                end
            end else begin
                // count_out is never 0 while RUN; hold rather than wrap if it ever were
                expire_flag <= 1'b0;
            end
        end else begin
            expire_flag <= 1'b0;
        end
    end

    // busy is a pure decode of the state register
    assign busy = (state == RUN);

endmodule
